tile_spawner: RTL and testbench
===============================

TILE_SPAWNER -- requirements
Module: tile_spawner

Interface
REQ-001 Parameter NUM_COLS, default 4, number of columns driven; legal values 2-8.
REQ-002 Parameter INIT_INTERVAL, default 40, frame ticks between spawns after reset or enable; legal values 1-255.
REQ-003 Parameter MIN_INTERVAL, default 12, lower bound on the spawn interval; legal values 1 to INIT_INTERVAL.
REQ-004 Parameter SPEEDUP_EVERY, default 8, number of successful spawns per interval reduction.
REQ-005 Parameter SPEEDUP_STEP, default 2, frame ticks removed from the interval per reduction.
REQ-006 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value; must be nonzero.
REQ-007 clk  input  1  system clock.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 frame_tick  input  1  one-clk pulse per video frame.
REQ-010 enable  input  1  high while the game is running.
REQ-011 col_active  input  NUM_COLS  per-column busy flag from each column's active output.
REQ-012 spawn  output  NUM_COLS  one-hot spawn request to the columns; registered.
REQ-013 spawn_count  output  16  total successful spawns.
REQ-014 interval_cur  output  8  current spawn interval in frame ticks.

Function
REQ-015 The FSM SHALL have states IDLE, COUNT, PICK and SPAWN, and SHALL exit reset in IDLE.
REQ-016 IDLE SHALL go to COUNT on the first clk with enable=1, loading frame_cnt with interval_cur.
REQ-017 COUNT SHALL decrement frame_cnt on each frame_tick and SHALL go to PICK on the frame_tick where frame_cnt==1.
REQ-018 On entry to PICK, cand SHALL equal lfsr mod NUM_COLS, and the LFSR SHALL advance exactly one step (16-bit Fibonacci, taps 16,14,13,11).
REQ-019 PICK SHALL test one candidate per clk: if col_active[cand]==0, go to SPAWN; otherwise cand = (cand+1) mod NUM_COLS.
REQ-020 If all NUM_COLS candidates are busy, PICK SHALL return to COUNT with frame_cnt=1, so it retries on the next frame_tick.
REQ-021 On entry to SPAWN, spawn SHALL go one-hot at bit cand.
REQ-022 spawn SHALL hold through and including the next frame_tick cycle, then clear on the following clk.
REQ-023 After a SPAWN exit, spawn_count SHALL increment (wrapping 65535 to 0) and the FSM SHALL return to COUNT with frame_cnt = interval_cur.
REQ-024 spawn SHALL never have more than one bit set, and SHALL be all-zero outside SPAWN.
REQ-025 In every non-IDLE state, enable=0 SHALL force IDLE on the next clk, clear spawn the same clk, and leave spawn_count, interval_cur and lfsr unchanged.
REQ-026 A frame_tick that arrives while in PICK SHALL be ignored.

Reset
REQ-027 Asynchronous reset SHALL set state=IDLE, spawn=0, spawn_count=0, interval_cur=INIT_INTERVAL, frame_cnt=0, lfsr=LFSR_SEED and the speedup counter to 0.
REQ-028 Reset asserted mid-SPAWN SHALL drop spawn immediately, with no clk edge required.

Configuration
REQ-029 Macro TILE_SPAWNER_SPEEDUP_EN.
  - Defined: after every SPEEDUP_EVERY successful spawns, interval_cur -= SPEEDUP_STEP, saturating at MIN_INTERVAL; the new value takes effect at the next COUNT load.
  - Undefined: interval_cur stays at INIT_INTERVAL permanently, and the speedup logic is absent.

Verification
REQ-030 Reset, enable=1, col_active=0, one frame_tick every 10 clks -> first spawn=4'b0010 (seed 16'hACE1, lfsr[1:0]=01), asserted after the 40th frame_tick and held through the 41st.
REQ-031 col_active=4'b1110 at the first pick -> candidates tested 1,2,3,0; spawn=4'b0001 on the 4th PICK clk.
REQ-032 col_active=4'b1111 at the pick -> no spawn; PICK retried after the next frame_tick; col_active released to 0 -> spawn issued on a retry.
REQ-033 enable dropped in the SPAWN cycle -> spawn=0 on the next clk, spawn_count unchanged, and re-enable restarts a full 40-tick count.
REQ-034 TILE_SPAWNER_SPEEDUP_EN defined, 8 spawns -> interval_cur=38; after 112 spawns -> interval_cur=12 and stays 12; macro undefined -> interval_cur remains 40.
REQ-035 Across 1000 spawns: $onehot0(spawn) always holds, and spawn_count equals the number of frame_ticks seen with spawn!=0.

Source files
------------

// File: rtl/tile_spawner.sv
// Spawns one tile per interval into a randomly chosen idle column (LFSR pick, linear probe).
// Build with TILE_SPAWNER_SPEEDUP_EN defined to shrink the interval as the game progresses.
module tile_spawner #(
  parameter int NUM_COLS      = 4,
  parameter int INIT_INTERVAL = 40,
  parameter int MIN_INTERVAL  = 12,
  parameter int SPEEDUP_EVERY = 8,
  parameter int SPEEDUP_STEP  = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_tick,
  input  logic                enable,
  input  logic [NUM_COLS-1:0] col_active,
  output logic [NUM_COLS-1:0] spawn,
  output logic [15:0]         spawn_count,
  output logic [7:0]          interval_cur,
  output logic [1:0]          state_dbg
);

  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, PICK = 2'd2, SPAWN = 2'd3} state_t;

  state_t          state;
  logic [7:0]      frame_cnt;
  logic [15:0]     lfsr;
  logic [CW-1:0]   cand;
  logic [CW-1:0]   tries;
  logic            lfsr_fb;
  logic [15:0]     lfsr_next;
  logic [CW-1:0]   cand_inc;
  logic [NUM_COLS-1:0] cand_onehot;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign lfsr_fb     = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign lfsr_next   = {lfsr_fb, lfsr[15:1]};
  assign cand_inc    = (cand == CW'(NUM_COLS - 1)) ? '0 : cand + 1'b1;
  assign cand_onehot = {{(NUM_COLS-1){1'b0}}, 1'b1} << cand;
  assign state_dbg   = state;

  // Handshake: spawn is a level request; the column takes it on the frame_tick it is held through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      spawn       <= '0;
      spawn_count <= '0;
      frame_cnt   <= '0;
      lfsr        <= LFSR_SEED;
      cand        <= '0;
      tries       <= '0;
    end else if (state != IDLE && !enable) begin
      state     <= IDLE;
      spawn     <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= COUNT;
            frame_cnt <= interval_cur;
          end
        end
        COUNT: begin
          if (frame_tick) begin
            if (frame_cnt <= 8'd1) begin
              state     <= PICK;
              cand      <= CW'(lfsr % 16'(NUM_COLS));
              tries     <= '0;
              lfsr      <= lfsr_next;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt - 8'd1;
            end
          end
        end
        PICK: begin
          if (!col_active[cand]) begin
            state <= SPAWN;
            spawn <= cand_onehot;
          end else if (tries == CW'(NUM_COLS - 1)) begin
            // Every column busy: retry on the very next frame_tick.
            state     <= COUNT;
            frame_cnt <= 8'd1;
          end else begin
            cand  <= cand_inc;
            tries <= tries + 1'b1;
          end
        end
        SPAWN: begin
          if (frame_tick) begin
            state       <= COUNT;
            spawn       <= '0;
            spawn_count <= spawn_count + 16'd1;
            frame_cnt   <= interval_cur;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TILE_SPAWNER_SPEEDUP_EN
  logic        spawn_done;
  logic [15:0] speed_cnt;

  assign spawn_done = (state == SPAWN) && enable && frame_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed_cnt    <= '0;
      interval_cur <= 8'(INIT_INTERVAL);
    end else if (spawn_done) begin
      if (speed_cnt == 16'(SPEEDUP_EVERY - 1)) begin
        speed_cnt <= '0;
        if (int'(interval_cur) >= MIN_INTERVAL + SPEEDUP_STEP)
          interval_cur <= interval_cur - 8'(SPEEDUP_STEP);
        else
          interval_cur <= 8'(MIN_INTERVAL);
      end else begin
        speed_cnt <= speed_cnt + 16'd1;
      end
    end
  end
`else
  assign interval_cur = 8'(INIT_INTERVAL);
`endif

endmodule

// File: tb/tb_tile_spawner.sv
// Directed bench for tile_spawner: first-spawn timing, probing, all-busy retry,
// enable drop, async reset, and a long randomized run checking one-hot and spawn counting.
module tb_tile_spawner;

  localparam logic [1:0] S_IDLE = 2'd0, S_COUNT = 2'd1, S_PICK = 2'd2, S_SPAWN = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  col_active = 4'b0000;
  logic [3:0]  spawn;
  logic [15:0] spawn_count;
  logic [7:0]  interval_cur;
  logic [1:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  int obs_spawns = 0;
  int cyc = 0;

  tile_spawner dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .col_active   (col_active),
    .spawn        (spawn),
    .spawn_count  (spawn_count),
    .interval_cur (interval_cur),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      wait_clks(9);
      do_tick();
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    enable     = 1'b0;
    frame_tick = 1'b0;
    col_active = 4'b0000;
    wait_clks(2);
    reset_n = 1'b1;
    wait_clks(1);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_spawn", 32'(spawn), 32'h0);
    check("rst_count", 32'(spawn_count), 32'h0);
    check("rst_interval", 32'(interval_cur), 32'd40);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));

    // First spawn: seed ACE1 -> cand 1, after the 40th tick, held through the 41st
    enable = 1'b1;
    wait_clks(1);
    check("en_state", 32'(state_dbg), 32'(S_COUNT));
    run_ticks(39);
    check("t39_state", 32'(state_dbg), 32'(S_COUNT));
    check("t39_spawn", 32'(spawn), 32'h0);
    run_ticks(1);
    check("t40_state", 32'(state_dbg), 32'(S_PICK));
    wait_clks(1);
    check("first_spawn", 32'(spawn), 32'b0010);
    wait_clks(9);
    check("first_hold", 32'(spawn), 32'b0010);
    do_tick();
    check("first_clear", 32'(spawn), 32'h0);
    check("first_count", 32'(spawn_count), 32'd1);
    check("first_ret_state", 32'(state_dbg), 32'(S_COUNT));

    // Linear probe: columns 1..3 busy, candidate order 1,2,3,0
    do_reset();
    enable = 1'b1;
    col_active = 4'b1110;
    wait_clks(1);
    run_ticks(40);
    wait_clks(3);
    check("probe_pick3", 32'(state_dbg), 32'(S_PICK));
    check("probe_spawn3", 32'(spawn), 32'h0);
    wait_clks(1);
    check("probe_spawn4", 32'(spawn), 32'b0001);
    col_active = 4'b0000;
    do_tick();
    check("probe_count", 32'(spawn_count), 32'd1);

    // All busy: no spawn, retry on next tick; lfsr 5670 -> cand 0, then AB38 -> cand 0
    col_active = 4'b1111;
    run_ticks(40);
    wait_clks(3);
    check("busy_pick", 32'(state_dbg), 32'(S_PICK));
    wait_clks(1);
    check("busy_back_count", 32'(state_dbg), 32'(S_COUNT));
    check("busy_no_spawn", 32'(spawn), 32'h0);
    col_active = 4'b0000;
    run_ticks(1);
    check("retry_pick", 32'(state_dbg), 32'(S_PICK));
    wait_clks(1);
    check("retry_spawn", 32'(spawn), 32'b0001);
    do_tick();
    check("retry_count", 32'(spawn_count), 32'd2);

    // Enable dropped during SPAWN (lfsr 559C -> cand 0)
    run_ticks(40);
    wait_clks(1);
    check("drop_pre_spawn", 32'(spawn), 32'b0001);
    enable = 1'b0;
    wait_clks(1);
    check("drop_spawn", 32'(spawn), 32'h0);
    check("drop_state", 32'(state_dbg), 32'(S_IDLE));
    check("drop_count", 32'(spawn_count), 32'd2);
    enable = 1'b1;
    wait_clks(1);
    run_ticks(39);
    check("restart_t39", 32'(state_dbg), 32'(S_COUNT));
    run_ticks(1);
    check("restart_t40", 32'(state_dbg), 32'(S_PICK));
    wait_clks(1);
    // lfsr 2ACE -> cand 2
    check("restart_spawn", 32'(spawn), 32'b0100);

    // Asynchronous reset mid-SPAWN drops spawn without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check("async_spawn", 32'(spawn), 32'h0);
    check("async_state", 32'(state_dbg), 32'(S_IDLE));
    check("async_count", 32'(spawn_count), 32'h0);
    #1;
    reset_n = 1'b1;
    wait_clks(1);

    // Long randomized run: one-hot, spawn only in SPAWN, count matches observed handoffs
    enable = 1'b1;
    obs_spawns = 0;
    cyc = 0;
    while (cyc < 80000 && obs_spawns < 1000) begin
      col_active = 4'($urandom_range(0, 15));
      frame_tick = ($urandom_range(0, 3) != 0);
      check("onehot0", 32'($onehot0(spawn)), 32'd1);
      if (spawn != 4'b0000) begin
        check("spawn_state", 32'(state_dbg), 32'(S_SPAWN));
        if (frame_tick) obs_spawns++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    frame_tick = 1'b0;
    check("run_budget", 32'(obs_spawns >= 1000), 32'd1);
    check("run_count", 32'(spawn_count), 32'(obs_spawns[15:0]));
`ifdef TILE_SPAWNER_SPEEDUP_EN
    check("run_interval", 32'(interval_cur), 32'd12);
`else
    check("run_interval", 32'(interval_cur), 32'd40);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
